div_serial_arbiter: RTL and testbench

- Shares one div_serial core between N_REQ independent requesters, using round-robin arbitration.
- Accepts requests on per-requester valid/ready channels and registers the operands.
- Sequences the core's start/done handshake, then returns quotient/remainder on per-requester response channels.
- Handles divide-by-zero locally, without using the core. Sits between CPU/accelerator ports and a single div_serial instance.

---
 rtl/div_serial_arbiter.sv | 140 ++++++++++++++
 tb/tb_div_serial_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_serial_arbiter.sv
// Round-robin front end sharing one div_serial core between N_REQ
// requesters; divide-by-zero is answered locally without the core.
module div_serial_arbiter #(
   parameter int DATA_W = 32,
   parameter int N_REQ  = 4,
   parameter int ID_W   = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ-1:0]        req_sign,
   input  logic [N_REQ*DATA_W-1:0] req_dividend,
   input  logic [N_REQ*DATA_W-1:0] req_divisor,
   output logic [N_REQ-1:0]        rsp_valid,
   input  logic [N_REQ-1:0]        rsp_ready,
   output logic [DATA_W-1:0]       rsp_quotient,
   output logic [DATA_W-1:0]       rsp_remainder,
   output logic [ID_W-1:0]         grant_id,
   output logic                    busy,
   output logic                    div_start,
   input  logic                    div_done,
   output logic                    div_sign,
   output logic [DATA_W-1:0]       div_dividend,
   output logic [DATA_W-1:0]       div_divisor,
   input  logic [DATA_W-1:0]       div_quotient,
   input  logic [DATA_W-1:0]       div_remainder
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_LO,
      WAIT_HI,
      ZERO,
      RESP
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [ID_W-1:0]   last_grant;
   logic [ID_W-1:0]   win_id;
   logic              win_vld;
   logic              take;
   logic [DATA_W-1:0] sel_dividend;
   logic [DATA_W-1:0] sel_divisor;

   // Scan starts just after the last served requester and wraps.
   always_comb begin : arb
      int idx;
      win_vld = 1'b0;
      win_id  = '0;
      idx     = 0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = int'(last_grant) + i;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!win_vld && req_valid[ID_W'(idx)]) begin
            win_vld = 1'b1;
            win_id  = ID_W'(idx);
         end
      end
   end

   assign take         = (state == IDLE) && div_done && win_vld;
   assign sel_dividend = req_dividend[int'(win_id)*DATA_W +: DATA_W];
   assign sel_divisor  = req_divisor[int'(win_id)*DATA_W +: DATA_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (take) begin
               state_nxt = (sel_divisor == '0) ? ZERO : START;
            end
         end
         START:   state_nxt = WAIT_LO;
         WAIT_LO: if (!div_done) state_nxt = WAIT_HI;
         WAIT_HI: if (div_done) state_nxt = RESP;
         ZERO:    state_nxt = RESP;
         RESP:    if (rsp_ready[grant_id]) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      div_start = (state == START);
      busy      = (state != IDLE);
      if (take) begin
         req_ready[win_id] = 1'b1;
      end
      if (state == RESP) begin
         rsp_valid[grant_id] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant    <= ID_W'(N_REQ - 1);
         grant_id      <= '0;
         div_sign      <= 1'b0;
         div_dividend  <= '0;
         div_divisor   <= '0;
         rsp_quotient  <= '0;
         rsp_remainder <= '0;
      end else begin
         if (take) begin
            grant_id     <= win_id;
            div_sign     <= req_sign[win_id];
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
         end
         // x/0 follows the RISC-V result: all ones, remainder = dividend.
         if (state == ZERO) begin
            rsp_quotient  <= '1;
            rsp_remainder <= div_dividend;
         end
         if (state == WAIT_HI && div_done) begin
            rsp_quotient  <= div_quotient;
            rsp_remainder <= div_remainder;
         end
         if (state == RESP && rsp_ready[grant_id]) begin
            last_grant <= grant_id;
         end
      end
   end

endmodule

// File: tb/tb_div_serial_arbiter.sv
// Scoreboard bench for div_serial_arbiter with a behavioural div_serial
// stand-in, directed cases and randomized multi-requester traffic.
module tb_div_serial_arbiter;
   localparam int DW = 32;
   localparam int N  = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    req_sign;
   logic [N*DW-1:0] req_dividend;
   logic [N*DW-1:0] req_divisor;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready;
   logic [DW-1:0]   rsp_quotient;
   logic [DW-1:0]   rsp_remainder;
   logic [IW-1:0]   grant_id;
   logic            busy;
   logic            div_start;
   logic            div_done;
   logic            div_sign;
   logic [DW-1:0]   div_dividend;
   logic [DW-1:0]   div_divisor;
   logic [DW-1:0]   div_quotient;
   logic [DW-1:0]   div_remainder;

   div_serial_arbiter #(.DATA_W(DW), .N_REQ(N), .ID_W(IW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_sign(req_sign),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
      .grant_id(grant_id), .busy(busy),
      .div_start(div_start), .div_done(div_done), .div_sign(div_sign),
      .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_remainder(div_remainder)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            k;
      logic          s;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] q;
      logic [DW-1:0] r;
      int            acc;
   } exp_t;

   exp_t sb[$];
   int   acc_log[$];

   logic [N-1:0]  want = '0;
   logic [N-1:0]  ws = '0;
   logic [DW-1:0] wa [N];
   logic [DW-1:0] wb [N];
   logic          rnd_mode = 1'b0;
   int            rnd_left = 0;
   logic [N-1:0]  rr_force = '1;
   int            last_g = N - 1;
   int            rsp_cnt = 0;
   int            done_rise = 0;
   logic          rst_hit = 1'b0;
   logic [DW-1:0] last_q;
   logic [DW-1:0] last_r;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // RISC-V division result from plain arithmetic.
   function automatic logic [63:0] ref_div(input logic s,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
      logic [DW-1:0] q;
      logic [DW-1:0] r;
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (!s) begin
         q = a / b;
         r = a % b;
      end else if (a == 32'h8000_0000 && b == '1) begin
         q = a;
         r = '0;
      end else begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end
      return {q, r};
   endfunction

   task automatic rnd_ops(input int k);
      ws[k] = 1'($urandom);
      wa[k] = $urandom;
      case ($urandom_range(0, 7))
         0:       wb[k] = '0;
         1:       wb[k] = '1;
         2: begin
            wa[k] = 32'h8000_0000;
            wb[k] = '1;
         end
         3, 4:    wb[k] = DW'($urandom_range(1, 15));
         default: wb[k] = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) wa[k] = DW'($urandom_range(0, 300));
   endtask

   task automatic post(input int k, input logic s,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
      ws[k]   = s;
      wa[k]   = a;
      wb[k]   = b;
      want[k] = 1'b1;
   endtask

   // Stimulus: drive after posedge, detect accepts and arbitrate the model.
   logic [N-1:0] exp_rdy;
   int           jj;
   int           kk;
   exp_t         ne;
   always begin
      @(posedge clk);
      #1;
      if (rnd_mode) begin
         for (int k = 0; k < N; k++) begin
            if (want[k]) begin
               if ($urandom_range(0, 15) == 0) want[k] = 1'b0;
               else if ($urandom_range(0, 3) == 0) rnd_ops(k);
            end else if (rnd_left > 0 && $urandom_range(0, 3) == 0) begin
               rnd_left--;
               rnd_ops(k);
               want[k] = 1'b1;
            end
         end
         rsp_ready = N'($urandom);
      end else begin
         rsp_ready = rr_force;
      end
      for (int k = 0; k < N; k++) begin
         req_valid[k]               = want[k];
         req_sign[k]                = ws[k];
         req_dividend[k*DW +: DW]   = wa[k];
         req_divisor[k*DW +: DW]    = wb[k];
      end
      @(negedge clk);
      #1;
      if (!rst) begin
         exp_rdy = '0;
         if (sb.size() == 0 && div_done) begin
            for (int i = 1; i <= N; i++) begin
               jj = (last_g + i) % N;
               if (exp_rdy == '0 && req_valid[jj]) exp_rdy[jj] = 1'b1;
            end
         end
         chk("req_ready", req_ready, exp_rdy);
         if (req_ready != '0) begin
            kk = -1;
            for (int k = N - 1; k >= 0; k--) if (req_ready[k]) kk = k;
            ne.k   = kk;
            ne.s   = req_sign[kk];
            ne.a   = req_dividend[kk*DW +: DW];
            ne.b   = req_divisor[kk*DW +: DW];
            {ne.q, ne.r} = ref_div(ne.s, ne.a, ne.b);
            ne.acc = cyc;
            sb.push_back(ne);
            acc_log.push_back(kk);
            last_g   = kk;
            want[kk] = 1'b0;
         end
      end
   end

   // Behavioural div_serial: done drops after start, rises with results.
   logic          cs;
   logic [DW-1:0] ca;
   logic [DW-1:0] cb;
   initial begin
      div_done      = 1'b1;
      div_quotient  = '0;
      div_remainder = '0;
      forever begin
         @(negedge clk);
         if (div_start === 1'b1) begin
            rst_hit = 1'b0;
            cs = div_sign;
            ca = div_dividend;
            cb = div_divisor;
            if (sb.size() == 0) begin
               chk("start_spurious", 1, 0);
            end else begin
               chk("start_cycle", cyc - sb[0].acc, 1);
               chk("start_grant", grant_id, sb[0].k);
               chk("start_dividend", ca, sb[0].a);
               chk("start_divisor", cb, sb[0].b);
               chk("start_sign", cs, sb[0].s);
            end
            if ($urandom_range(0, 1) == 1) begin
               @(negedge clk);
               chk("start_pulse", div_start, 0);
            end
            div_done      = 1'b0;
            div_quotient  = $urandom;
            div_remainder = $urandom;
            repeat ($urandom_range(2, 6)) @(negedge clk);
            if (!rst_hit) begin
               chk("hold_dividend", div_dividend, ca);
               chk("hold_divisor", div_divisor, cb);
               chk("hold_sign", div_sign, cs);
            end
            {div_quotient, div_remainder} = ref_div(cs, ca, cb);
            div_done  = 1'b1;
            done_rise = cyc;
         end
      end
   end

   // Monitor: compare every presented response with the scoreboard head.
   logic [N-1:0] prev_valid = '0;
   logic [N-1:0] oh;
   exp_t         e;
   always begin
      @(negedge clk);
      #2;
      if (rst || rsp_valid == '0) begin
         prev_valid = '0;
      end else if (sb.size() == 0) begin
         chk("rsp_spurious", rsp_valid, 0);
         prev_valid = rsp_valid;
      end else begin
         e = sb[0];
         oh = '0;
         oh[e.k] = 1'b1;
         chk("rsp_valid", rsp_valid, oh);
         chk("rsp_quotient", rsp_quotient, e.q);
         chk("rsp_remainder", rsp_remainder, e.r);
         if (prev_valid == '0) begin
            if (e.b == '0) chk("zero_latency", cyc - e.acc, 2);
            else chk("rsp_latency", cyc - done_rise, 1);
         end
         if (rsp_ready[e.k]) begin
            void'(sb.pop_front());
            last_q = rsp_quotient;
            last_r = rsp_remainder;
            rsp_cnt++;
            prev_valid = '0;
         end else begin
            prev_valid = rsp_valid;
         end
      end
   end

   task automatic wait_acc(input int n, input string what);
      int t = 0;
      while (acc_log.size() < n && t < 300) begin
         @(negedge clk);
         #3;
         t++;
      end
      chk(what, acc_log.size() >= n, 1);
   endtask

   task automatic wait_rsp(input int n, input string what);
      int t = 0;
      while (rsp_cnt < n && t < 400) begin
         @(negedge clk);
         #3;
         t++;
      end
      chk(what, rsp_cnt >= n, 1);
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      rst_hit = 1'b1;
      want    = '0;
      sb.delete();
      last_g  = N - 1;
      repeat (12) @(negedge clk);
      #3;
      rst = 1'b0;
   endtask

   int exp_order [5] = '{0, 1, 2, 3, 0};
   int base;

   initial begin
      rst          = 1'b1;
      req_valid    = '0;
      req_sign     = '0;
      req_dividend = '0;
      req_divisor  = '0;
      rsp_ready    = '0;
      for (int k = 0; k < N; k++) begin
         wa[k] = '0;
         wb[k] = '0;
      end
      repeat (2) @(negedge clk);
      #3;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_div_start", div_start, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_rsp_q", rsp_quotient, 0);
      chk("rst_rsp_r", rsp_remainder, 0);
      chk("rst_div_dividend", div_dividend, 0);
      chk("rst_div_divisor", div_divisor, 0);
      chk("rst_div_sign", div_sign, 0);
      rst = 1'b0;

      // single request from requester 0
      acc_log.delete();
      post(0, 1'b0, 32'd100, 32'd7);
      wait_acc(1, "t1_accept");
      if (acc_log.size() > 0) chk("t1_winner", acc_log[0], 0);
      @(negedge clk);
      #3;
      chk("t1_div_start", div_start, 1);
      chk("t1_grant_id", grant_id, 0);
      wait_rsp(1, "t1_response");
      chk("t1_quotient", last_q, 14);
      chk("t1_remainder", last_r, 2);

      // all four contend from reset; requester 0 comes back once
      do_reset();
      acc_log.delete();
      base = rsp_cnt;
      for (int k = 0; k < N; k++) post(k, 1'b0, DW'(k * 1000 + 5), DW'(k + 3));
      wait_acc(1, "t2_first_accept");
      post(0, 1'b0, 32'd7777, 32'd9);
      wait_rsp(base + 5, "t2_responses");
      chk("t2_count", acc_log.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < acc_log.size()) chk("t2_order", acc_log[i], exp_order[i]);
      end

      // divide by zero on requester 2
      base = rsp_cnt;
      post(2, 1'b0, 32'h1234, 32'd0);
      wait_rsp(base + 1, "t3_response");
      chk("t3_quotient", last_q, 32'hFFFF_FFFF);
      chk("t3_remainder", last_r, 32'h1234);

      // signed division on requester 1
      base = rsp_cnt;
      acc_log.delete();
      post(1, 1'b1, 32'hFFFF_FFEC, 32'd3);
      wait_acc(1, "t4_accept");
      @(negedge clk);
      #3;
      chk("t4_div_sign", div_sign, 1);
      wait_rsp(base + 1, "t4_response");
      chk("t4_quotient", last_q, 32'hFFFF_FFFA);
      chk("t4_remainder", last_r, 32'hFFFF_FFFE);

      // back-pressure on requester 3 while requester 0 waits
      base = rsp_cnt;
      rr_force = 4'b0111;
      post(3, 1'b0, 32'd5000, 32'd13);
      for (int t = 0; t < 100 && rsp_valid[3] !== 1'b1; t++) begin
         @(negedge clk);
         #3;
      end
      chk("t5_rsp_present", rsp_valid, 4'b1000);
      post(0, 1'b0, 32'd99, 32'd4);
      repeat (10) begin
         @(negedge clk);
         #3;
         chk("t5_hold_valid", rsp_valid, 4'b1000);
         chk("t5_no_grant", req_ready, 0);
         chk("t5_hold_q", rsp_quotient, 32'd384);
         chk("t5_hold_r", rsp_remainder, 32'd8);
      end
      rr_force = '1;
      wait_rsp(base + 2, "t5_responses");

      // reset while waiting for done to fall
      acc_log.delete();
      post(1, 1'b0, 32'd4321, 32'd5);
      wait_acc(1, "t6_accept");
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("t6_busy_before", busy, 1);
      rst     = 1'b1;
      rst_hit = 1'b1;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_grant_id", grant_id, 0);
      chk("t6_div_start", div_start, 0);
      chk("t6_div_dividend", div_dividend, 0);
      chk("t6_div_divisor", div_divisor, 0);
      chk("t6_rsp_valid", rsp_valid, 0);
      do_reset();
      acc_log.delete();
      base = rsp_cnt;
      post(0, 1'b0, 32'd1000, 32'd3);
      post(3, 1'b1, 32'hFFFF_FF00, 32'd7);
      wait_rsp(base + 2, "t6_responses");
      chk("t6_count", acc_log.size(), 2);
      if (acc_log.size() == 2) begin
         chk("t6_first", acc_log[0], 0);
         chk("t6_second", acc_log[1], 3);
      end

      // randomized traffic
      rnd_left = 300;
      rnd_mode = 1'b1;
      for (int t = 0; t < 20000 && rnd_left > 0; t++) begin
         @(negedge clk);
         #3;
      end
      chk("rnd_issue_done", rnd_left, 0);
      rnd_mode = 1'b0;
      want     = '0;
      for (int t = 0; t < 500 && sb.size() != 0; t++) begin
         @(negedge clk);
         #3;
      end
      chk("rnd_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
